fp_subtractor_seq: RTL and testbench
====================================

# fp_subtractor_seq

Multi-cycle IEEE-754 single-precision subtractor computing `a - b`: the inverse-direction companion of the team's combinational floating-point adder. It sits on the same 32-bit operand buses. Beyond the adder, it adds what subtraction needs: magnitude compare/swap, effective add/subtract selection, and iterative left normalization. Operands enter and results leave through valid/ready handshakes.

## Interface
- No parameters; fixed single precision (1/8/23).
- `clk` in 1: only clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair `a`, `b` valid.
- `in_ready` out 1: block idle, can accept operands.
- `a` in 32: minuend, IEEE single.
- `b` in 32: subtrahend, IEEE single.
- `out_valid` out 1: `result`/`ovf` valid; held until accepted.
- `out_ready` in 1: consumer accepts result.
- `result` out 32: `a - b`, IEEE single.
- `ovf` out 1: exponent overflow; `result` is ±infinity.

## Operation
- States: IDLE, ALIGN, ARITH, NORM, ROUND (macro only), DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`, register `a` and `{~b[31], b[30:0]}`, then go to ALIGN.
- Operand decode:
  - Exponent 0 means the operand is zero (denormals flushed).
  - Exponent 255 is not supported; behaviour is undefined.
  - Hidden bit = 1 for nonzero operands.
- ALIGN, one cycle:
  - Compare `{exp,frac}` magnitudes and swap so L ≥ S.
  - Datapath is 27 bits: hidden bit, 23 fraction bits, then guard/round/sticky (G/R/S).
  - Right-shift S by `expL - expS` in one step.
  - Shift ≥ 27 makes S zero, with sticky = OR of S.
  - Sticky is the OR of all bits shifted out.
- ARITH, one cycle:
  - Signs equal: add, keeping the carry (28-bit sum). Otherwise subtract L - S.
  - Working exponent = `expL`. Sign = sign of L.
  - Difference == 0 gives `result=0x00000000` (+0); go to DONE.
- NORM:
  - First cycle: if carry, shift right 1 with sticky OR and exponent+1.
  - Exponent reaching 255 gives `result={sign,8'hFF,23'h0}`, `ovf=1`, go to DONE (rounding skipped).
  - Each cycle after that, while bit26==0: shift left 1 and exponent-1. One shift per cycle, at most 26 shifts.
  - If the exponent would drop below 1, flush to +0 and go to DONE.
  - When bit26==1: go to ROUND (macro) or DONE.
- DONE:
  - `out_valid=1`; `result`, `ovf` stable.
  - On `out_ready` go to IDLE. `out_valid` drops the next cycle.
- Without rounding: fraction = bits[25:3], truncate.

## Timing
- Acceptance edge = cycle 0.
- `out_valid` rises at cycle 3+n, where n = number of left-normalization shifts (0..26). Rounding adds +1.
- Zero and overflow results take the shortest path: zero at cycle 3, overflow at cycle 3+0 (+0 with macro, since rounding is skipped).
- `in_ready=0` from cycle 1 until the cycle after the output handshake. There is no overlap between operations.
- `out_ready` high while `out_valid=0` is ignored.
- Operand inputs are sampled only at acceptance. Later changes have no effect.
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `ovf=0`.
- Reset in any state aborts the operation with no `out_valid` pulse. Operands are dropped.
- `ovf` clears on the next acceptance.

## Configuration
- `FPSUB_ROUND_EN` defined:
  - ROUND state applies round-to-nearest-even on G/R/S. A tie rounds up only when the LSB is 1.
  - A mantissa carry-out sets fraction=0 and exponent+1.
  - Exponent 255 after rounding gives infinity with `ovf=1`.
  - Adds one cycle of latency.
- Undefined: ROUND state absent; truncation only.

## Test plan
- `a=0x40400000`, `b=0x3F800000` (3-1) -> `result=0x40000000`, `ovf=0`, `out_valid` at cycle 3 (4 with macro).
- `a=0x3F800000`, `b=0x3F800000` -> `result=0x00000000`, `out_valid` at cycle 3. Same with `b=0xBF800000` -> `0x40000000` (add path, carry).
- `a=0x3F800000`, `b=0x3F7FFFFF` -> `result=0x33800000` (2^-24), 24 shifts, `out_valid` at cycle 27 (28 with macro).
- `a=0x3F800000`, `b=0x33000000` -> `0x3F7FFFFF` without the macro, `0x3F800000` with `FPSUB_ROUND_EN` (tie to even).
- `a=0x7F7FFFFF`, `b=0xFF7FFFFF` -> `result=0x7F800000`, `ovf=1`.
- Hold `out_ready=0` for 5 cycles -> `out_valid`, `result` stable, `in_ready=0`. Assert `rst` mid-NORM on the next operation -> IDLE next cycle, `out_valid=0`, `result=0`.

Source files
------------

// File: rtl/fp_subtractor_seq_if.sv
// Operand/result handshake bundle for fp_subtractor_seq.
// master: operand producer and result consumer; slave: the subtractor.
interface fp_subtractor_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        ovf;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, ovf
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, ovf
   );
endinterface

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: result = a - b.
// Denormals flush to zero; exponent 255 inputs are unsupported.
// Optional macro FPSUB_ROUND_EN adds a ROUND state (round-to-nearest-even);
// without it the fraction is truncated.
module fp_subtractor_seq (
   input  logic                clk,
   input  logic                rst,
   fp_subtractor_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ARITH,
      NORM,
`ifdef FPSUB_ROUND_EN
      ROUND,
`endif
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sign_q, sign_d;
   logic        sub_q, sub_d;
   logic [7:0]  exp_q, exp_d;
   logic [26:0] ml_q, ml_d;
   logic [26:0] ms_q, ms_d;
   logic [27:0] mant_q, mant_d;
   logic [31:0] result_q, result_d;
   logic        ovf_q, ovf_d;

   logic        swap;
   logic [31:0] l_op, s_op;
   logic [26:0] l_m, s_m, s_al, lost;
   logic [7:0]  sh;
   logic [27:0] sum;
   logic [27:0] rsh_m, norm_m;
   logic [7:0]  exp_inc, norm_e;
`ifdef FPSUB_ROUND_EN
   logic        rnd_up;
   logic [24:0] rsum;
   logic [7:0]  rnd_e;
`endif

   // Magnitude compare/swap and single-step alignment of the smaller operand
   always_comb begin
      swap = b_q[30:0] > a_q[30:0];
      l_op = swap ? b_q : a_q;
      s_op = swap ? a_q : b_q;
      l_m  = {|l_op[30:23], l_op[22:0], 3'b000};
      s_m  = {|s_op[30:23], s_op[22:0], 3'b000};
      sh   = l_op[30:23] - s_op[30:23];
      lost = '0;
      s_al = '0;
      if (sh >= 8'd27) begin
         s_al = {26'd0, |s_m};
      end else begin
         lost = s_m & ~(27'h7FF_FFFF << sh);
         s_al = (s_m >> sh) | {26'd0, |lost};
      end
   end

   // Effective add/subtract plus normalization and rounding helpers
   always_comb begin
      sum     = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
      rsh_m   = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
      exp_inc = exp_q + 8'd1;
      norm_m  = mant_q[27] ? rsh_m : mant_q;
      norm_e  = mant_q[27] ? exp_inc : exp_q;
`ifdef FPSUB_ROUND_EN
      rnd_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
      rsum    = {1'b0, mant_q[26:3]} + {24'd0, rnd_up};
      rnd_e   = rsum[24] ? exp_inc : exp_q;
`endif
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      sub_d    = sub_q;
      exp_d    = exp_q;
      ml_d     = ml_q;
      ms_d     = ms_q;
      mant_d   = mant_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = {~bus.b[31], bus.b[30:0]};
               ovf_d   = 1'b0;
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            sign_d  = l_op[31];
            sub_d   = l_op[31] ^ s_op[31];
            exp_d   = l_op[30:23];
            ml_d    = l_m;
            ms_d    = s_al;
            state_d = ARITH;
         end
         ARITH: begin
            // A zero difference forces exponent 0 so NORM's flush-to-zero
            // path emits +0 on its first cycle, keeping the zero latency fixed.
            mant_d = sum;
            if (sum == '0) exp_d = 8'd0;
            state_d = NORM;
         end
         NORM: begin
            if (mant_q[27] && exp_inc == 8'hFF) begin
               result_d = {sign_q, 8'hFF, 23'd0};
               ovf_d    = 1'b1;
               state_d  = DONE;
            end else if (!mant_q[27] && !mant_q[26]) begin
               if (exp_q <= 8'd1) begin
                  result_d = '0;
                  state_d  = DONE;
               end else begin
                  mant_d = mant_q << 1;
                  exp_d  = exp_q - 8'd1;
               end
            end else begin
               mant_d = norm_m;
               exp_d  = norm_e;
`ifdef FPSUB_ROUND_EN
               state_d = ROUND;
`else
               result_d = {sign_q, norm_e, norm_m[25:3]};
               state_d  = DONE;
`endif
            end
         end
`ifdef FPSUB_ROUND_EN
         ROUND: begin
            if (rnd_e == 8'hFF) begin
               result_d = {sign_q, 8'hFF, 23'd0};
               ovf_d    = 1'b1;
            end else begin
               result_d = {sign_q, rnd_e, rsum[24] ? 23'd0 : rsum[22:0]};
            end
            state_d = DONE;
         end
`endif
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         ml_q     <= '0;
         ms_q     <= '0;
         mant_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         ml_q     <= ml_d;
         ms_q     <= ms_d;
         mant_q   <= mant_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: vector table with a scoreboard
// queue, plus backpressure and mid-operation reset sequences.
module tb_fp_subtractor_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_subtractor_seq_if bus ();

   fp_subtractor_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef FPSUB_ROUND_EN
   localparam int          RL      = 1;
   localparam logic [31:0] TIE_RES = 32'h3F80_0000;
`else
   localparam int          RL      = 0;
   localparam logic [31:0] TIE_RES = 32'h3F7F_FFFF;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic o, input int lat);
      exp_t e;
      int   k;
      bit   seen;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      e.res = res;
      e.ovf = o;
      e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = ~a;
      bus.b        = ~b;
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.out_valid) seen = 1'b1;
      end
      e = sb.pop_front();
      check("out_valid_seen", 32'(seen), 32'd1);
      check("latency", 32'(k), 32'(e.lat));
      check("result", bus.result, e.res);
      check("ovf", 32'(bus.ovf), 32'(e.ovf));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("valid_drop", 32'(bus.out_valid), 32'd0);
      check("ready_back", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[11];
      int   k;
      int   stray;

      vecs[0]  = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3 + RL};  // 3 - 1
      vecs[1]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 3};       // exact zero
      vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 3 + RL};  // add with carry
      vecs[3]  = '{32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000, 1'b0, 27 + RL}; // 24 shifts
      vecs[4]  = '{32'h3F80_0000, 32'h3300_0000, TIE_RES,       1'b0, 4 + RL};  // tie, odd lsb
      vecs[5]  = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 3};       // overflow
      vecs[6]  = '{32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 3};       // underflow flush
      vecs[7]  = '{32'h3F80_0000, 32'h0080_0000, TIE_RES,       1'b0, 4 + RL};  // shift >= 27, sticky
      vecs[8]  = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 1'b0, 3 + RL};  // 0 - 2, swap
      vecs[9]  = '{32'hBFC0_0000, 32'h3E80_0000, 32'hBFE0_0000, 1'b0, 3 + RL};  // -1.5 - 0.25
      vecs[10] = '{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0000, 1'b0, 3 + RL};  // tie, even lsb

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);

      // out_ready while idle must not produce anything
      @(negedge clk);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_out_ready", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat);
      end

      // Backpressure: overflow result held for 5 cycles
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h7F7F_FFFF;
      bus.b        = 32'hFF7F_FFFF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("bp_latency", 32'(k), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_result", bus.result, 32'h7F80_0000);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp_ovf_held", 32'(bus.ovf), 32'd1);

      // Next operation clears ovf at acceptance; reset lands mid-NORM
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h3F80_0000;
      bus.b        = 32'h3F7F_FFFF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("ovf_clear", 32'(bus.ovf), 32'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) stray++;
      end
      check("midrst_no_pulse", 32'(stray), 32'd0);

      // Accept a fresh operation after the abort
      run_op(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3 + RL);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
